mux_nx1_rr: RTL and testbench
=============================

# mux_nx1_rr

Parametrised N-input, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes and a registered valid/ready output. It succeeds the combinational 4x1 mux: channel count and width are generic, selection is either externally driven or round-robin arbitrated, and the output beat is held until the consumer accepts it. It sits between several producers and one shared consumer, such as a shared bus port or a result collector.

## Interface
- `WIDTH`, 4: data width per channel, at least 1.
- `N`, 4: number of input channels, at least 2.
- `MODE`, 1: 0 = select-driven (`sel` picks the channel); 1 = round-robin arbitration (`sel` ignored).
- `SW`, derived as `$clog2(N)`: width of the select and channel-index signals.

- `clk`  in  1  the block's single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready, combinational, at most one bit set (one-hot or zero).
- `sel`  in  SW  channel select, used only when MODE=0.
- `out_data`  out  WIDTH  registered output data.
- `out_ch`  out  SW  index of the channel that supplied `out_data`.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer accepts the beat when `out_valid` and `out_ready` are both 1.

## Operation
- State:
  - output register (`out_data`, `out_ch`, `out_valid`);
  - round-robin pointer `ptr` (SW bits, MODE=1 only).
- Load enable: `load = !out_valid || out_ready`.
- Grant, MODE=0: `g = sel`, valid when `sel < N` and `in_valid[sel]`. When `sel >= N` there is no grant.
- Grant, MODE=1: `g` is the first i with `in_valid[i]`, scanning `ptr, ptr+1, …, N-1, 0, …, ptr-1`. The grant is valid when any `in_valid` bit is 1.
- `in_ready[i] = load && grant_valid && (g == i)`. A transfer on channel i occurs when both `in_valid[i]` and `in_ready[i]` are 1.
- On a rising edge with `load`:
  - With a grant: `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`. In MODE=1, `ptr <= (g == N-1) ? 0 : g+1`.
  - Without a grant: `out_valid <= 0`. `out_data`, `out_ch` and `ptr` hold their values.
- Without `load` (output stalled): all state holds and every `in_ready` bit is 0.
- Fairness (MODE=1): if all N channels stay valid, the grants rotate 0,1,…,N-1,0,…. No channel waits more than N-1 grants.
- In MODE=0, `ptr` stays at 0 and is unused.

## Timing
- Reset (`rst_n` = 0 at a rising edge): `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `ptr = 0`. `in_ready` is all zero during reset.
- Reset applied mid-operation discards the held beat, even if `out_valid` was 1. There is no transfer that cycle.
- Latency is 1 cycle from an input transfer to `out_valid`.
- Throughput is one beat per cycle while `out_ready` is held at 1.
- Drain and load in the same cycle: with `out_valid && out_ready` and a grant present, the next beat replaces the current one with no bubble.
- Stall behaviour: while `out_valid && !out_ready`, `out_data` and `out_ch` stay stable. Input valids may come and go with no effect.
- `sel` changes in MODE=0 take effect on the next load. The held beat is never altered.
- `in_ready` depends combinationally on `out_valid`, `out_ready`, `in_valid`, `sel` and `ptr`. It has no dependence on `in_data`.

## Test plan
Common setup: N=4, WIDTH=4, channel data a=0010, b=1001, c=1110, d=0011.

1. Reset: hold `rst_n`=0 for 2 cycles with all `in_valid`=1111 -> `out_valid`=0, `out_data`=0000, `out_ch`=0, `in_ready`=0000. After release, the first grant is channel 0 and `out_data`=0010 one cycle later.
2. MODE=0 sweep: `in_valid`=1111, `out_ready`=1, `sel` stepping 2,3,0,1 every cycle -> `out_data` is 1110, 0011, 0010, 1001 on consecutive cycles, each one cycle after its `sel`. `out_ch` matches `sel`.
3. MODE=1 rotation: `in_valid`=1111, `out_ready`=1 for 8 cycles -> `out_ch` is 0,1,2,3,0,1,2,3 and `out_data` is 0010, 1001, 1110, 0011 repeating.
4. MODE=1 skip and wrap: `in_valid`=1010 (channels 1 and 3) -> `out_ch` alternates 1,3,1,3. `in_ready` is never set for channels 0 or 2.
5. Backpressure: during rotation, drop `out_ready` for 3 cycles while `out_data`=1001 -> `out_data`/`out_ch` hold at 1001/1, `in_ready`=0000. On the first cycle `out_ready`=1, channel 2 is granted and `out_data`=1110 follows with no gap.
6. Empty and mid-op reset: `in_valid`=0000 with `out_ready`=1 -> `out_valid` falls to 0 the next cycle. Then with `out_valid`=1, `out_ready`=0, pulse `rst_n`=0 for one cycle -> `out_valid`=0, `ptr`=0, and the next grant with `in_valid`=1111 is channel 0.

Source files
------------

// File: rtl/mux_nx1_rr.sv
// N-input registered multiplexer with valid/ready handshakes on every channel.
// A channel is chosen either by an external select or by round-robin arbitration.
module mux_nx1_rr #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int MODE  = 1,
  parameter int SW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SW-1:0]        sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic             r_outValid;
  logic [WIDTH-1:0] r_outData;
  logic [SW-1:0]    r_outCh;
  logic [SW-1:0]    r_ptr;

  logic             w_load;
  logic             w_grantValid;
  logic [SW-1:0]    w_grant;
  logic [WIDTH-1:0] w_grantData;

  assign w_load = !r_outValid || out_ready;

  // Round-robin scan runs from the highest offset down, so the channel
  // closest to the pointer is the last one written and therefore wins.
  always_comb begin : grantLogic
    int idx;
    idx          = 0;
    w_grantValid = 1'b0;
    w_grant      = '0;
    if (MODE == 0) begin
      if (int'(sel) < N) begin
        w_grant      = sel;
        w_grantValid = in_valid[sel];
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(r_ptr) + k) % N;
        if (in_valid[idx]) begin
          w_grantValid = 1'b1;
          w_grant      = SW'(idx);
        end
      end
    end
  end

  assign w_grantData = in_data[w_grant*WIDTH +: WIDTH];

  // Reset gating keeps the producers from seeing a handshake that will be discarded.
  assign in_ready = (rst_n && w_load && w_grantValid) ? (N'(1) << w_grant) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outCh    <= '0;
      r_ptr      <= '0;
    end else if (w_load) begin
      if (w_grantValid) begin
        r_outValid <= 1'b1;
        r_outData  <= w_grantData;
        r_outCh    <= w_grant;
        if (MODE != 0) begin
          r_ptr <= (w_grant == SW'(N - 1)) ? '0 : w_grant + SW'(1);
        end
      end else begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_ch    = r_outCh;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Drives a select-mode and a round-robin instance with the same producers and
// compares both against a queue-based behavioural model of the multiplexer.
module tb_mux_nx1_rr;

  localparam int WIDTH = 4;
  localparam int N     = 4;
  localparam int SW    = 2;

  logic               clk;
  logic               rstN;
  logic [N*WIDTH-1:0] inData;
  logic [N-1:0]       inValid;
  logic [SW-1:0]      sel;
  logic               outReady;

  logic [N-1:0]     inReady0, inReady1;
  logic [WIDTH-1:0] outData0, outData1;
  logic [SW-1:0]    outCh0, outCh1;
  logic             outValid0, outValid1;

  int errors = 0;
  int checks = 0;

  bit       mValid[2];
  int       mData[2];
  int       mCh[2];
  int       order[$];

  mux_nx1_rr #(.WIDTH(WIDTH), .N(N), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rstN), .in_data(inData), .in_valid(inValid),
    .in_ready(inReady0), .sel(sel), .out_data(outData0), .out_ch(outCh0),
    .out_valid(outValid0), .out_ready(outReady)
  );

  mux_nx1_rr #(.WIDTH(WIDTH), .N(N), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rstN), .in_data(inData), .in_valid(inValid),
    .in_ready(inReady1), .sel(sel), .out_data(outData1), .out_ch(outCh1),
    .out_valid(outValid1), .out_ready(outReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  // Mode 1 keeps channels in priority order; a granted channel moves to the back.
  task automatic modelGrant(input int m, output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (m == 0) begin
      if (int'(sel) < N && inValid[sel]) begin
        gv = 1'b1;
        g  = int'(sel);
      end
    end else begin
      foreach (order[p]) begin
        if (!gv && inValid[order[p]]) begin
          gv = 1'b1;
          g  = order[p];
        end
      end
    end
  endtask

  task automatic modelReady(input int m, output int rdy);
    bit gv;
    int g;
    modelGrant(m, gv, g);
    rdy = (rstN && (!mValid[m] || outReady) && gv) ? (1 << g) : 0;
  endtask

  task automatic modelClock();
    bit gv[2];
    int g[2];
    int f;
    for (int m = 0; m < 2; m++) modelGrant(m, gv[m], g[m]);
    for (int m = 0; m < 2; m++) begin
      if (!rstN) begin
        mValid[m] = 1'b0;
        mData[m]  = 0;
        mCh[m]    = 0;
        if (m == 1) order = '{0, 1, 2, 3};
      end else if (!mValid[m] || outReady) begin
        if (gv[m]) begin
          mValid[m] = 1'b1;
          mData[m]  = int'(inData[g[m]*WIDTH +: WIDTH]);
          mCh[m]    = g[m];
          if (m == 1) begin
            do begin
              f = order.pop_front();
              order.push_back(f);
            end while (f != g[m]);
          end
        end else begin
          mValid[m] = 1'b0;
        end
      end
    end
  endtask

  // One cycle: drive at the falling edge, check ready before the rising edge,
  // check the registered outputs just after it.
  task automatic applyStimulus(input bit r, input logic [N-1:0] v, input logic [SW-1:0] s,
                               input bit rdy, input logic [N*WIDTH-1:0] d);
    int expReady;
    rstN     = r;
    inValid  = v;
    sel      = s;
    outReady = rdy;
    inData   = d;
    #1;
    modelReady(0, expReady);
    checkOutput("sel in_ready", 32'(inReady0), 32'(expReady));
    modelReady(1, expReady);
    checkOutput("rr in_ready", 32'(inReady1), 32'(expReady));
    @(posedge clk);
    modelClock();
    #1;
    checkOutput("sel out_valid", 32'(outValid0), 32'(mValid[0]));
    checkOutput("sel out_data", 32'(outData0), 32'(mData[0]));
    checkOutput("sel out_ch", 32'(outCh0), 32'(mCh[0]));
    checkOutput("rr out_valid", 32'(outValid1), 32'(mValid[1]));
    checkOutput("rr out_data", 32'(outData1), 32'(mData[1]));
    checkOutput("rr out_ch", 32'(outCh1), 32'(mCh[1]));
    @(negedge clk);
  endtask

  initial begin
    logic [N*WIDTH-1:0] abcd;
    logic [SW-1:0]      selSeq[4];
    abcd      = 16'h3E92;
    selSeq    = '{2'd2, 2'd3, 2'd0, 2'd1};
    mValid    = '{1'b0, 1'b0};
    mData     = '{0, 0};
    mCh       = '{0, 0};
    order     = '{0, 1, 2, 3};
    rstN      = 1'b0;
    inValid   = '0;
    sel       = '0;
    outReady  = 1'b1;
    inData    = abcd;
    @(negedge clk);

    repeat (2) applyStimulus(1'b0, 4'b1111, 2'd0, 1'b1, abcd);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'b1111, selSeq[i % 4], 1'b1, abcd);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b1010, 2'd1, 1'b1, abcd);
    applyStimulus(1'b1, 4'b1111, 2'd1, 1'b1, abcd);
    repeat (3) applyStimulus(1'b1, 4'b1111, 2'd2, 1'b0, abcd);
    repeat (2) applyStimulus(1'b1, 4'b1111, 2'd2, 1'b1, abcd);
    applyStimulus(1'b1, 4'b0000, 2'd0, 1'b1, abcd);
    applyStimulus(1'b1, 4'b1111, 2'd3, 1'b1, abcd);
    applyStimulus(1'b1, 4'b1111, 2'd3, 1'b0, abcd);
    applyStimulus(1'b0, 4'b1111, 2'd3, 1'b0, abcd);
    repeat (3) applyStimulus(1'b1, 4'b1111, 2'd1, 1'b1, abcd);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) != 0, N'($urandom), SW'($urandom),
                    $urandom_range(0, 3) != 0, (N*WIDTH)'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
